// File: rtl/rotate_sel_ctrl.sv
// rotate_sel_ctrl: rotation selector sequencer for the four-digit HEX display.
// Produces a modulo-POSITIONS selector that advances automatically every
// TICK_DIV cycles while running, or once per debounced-by-sync key press while
// paused. Emits one-cycle tick/wrap strobes aligned with each new selector value.
module rotate_sel_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int POSITIONS = 4,
  localparam int SEL_W    = (POSITIONS > 1) ? $clog2(POSITIONS) : 1
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             run_en,
  input  logic             dir,
  input  logic             step_n,
  output logic [SEL_W-1:0] sel,
  output logic             tick,
  output logic             wrap,
  output logic [1:0]       state
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0]   SEL_MAX   = SEL_W'(POSITIONS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;

  // Key synchroniser chain; all stages idle high (key released).
  logic               s1_q, s2_q, s2_dly_q;
  logic               step_ev;
  logic               do_adv;

  // Two-flop synchroniser plus edge-detect delay for the active-low key.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s2_dly_q <= 1'b1;
    end else begin
      s1_q     <= step_n;
      s2_q     <= s1_q;
      s2_dly_q <= s2_q;
    end
  end

  // High for exactly one cycle per press: the synchronised key just fell.
  assign step_ev = s2_dly_q & ~s2_q;

  // Next-state, prescaler and advance-request logic.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    do_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_en) begin
          state_d = RUN;
        end else if (step_ev) begin
          state_d = PAUSE;
          do_adv  = 1'b1;
        end
      end
      RUN: begin
        // Dropping run_en pauses immediately; the partial count is discarded
        // so that the next RUN entry starts a full TICK_DIV interval.
        if (!run_en) begin
          state_d = PAUSE;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          do_adv  = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSE: begin
        // A press coinciding with run_en rising is deliberately dropped.
        if (run_en) begin
          state_d = RUN;
        end else if (step_ev) begin
          do_adv = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Selector update with modulo wrap in either direction.
  always_comb begin
    sel_d  = sel_q;
    tick_d = do_adv;
    wrap_d = 1'b0;
    if (do_adv) begin
      if (dir) begin
        if (sel_q == '0) begin
          sel_d  = SEL_MAX;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q - 1'b1;
        end
      end else begin
        if (sel_q >= SEL_MAX) begin
          sel_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
    end
  end

  // State, prescaler, selector and strobe registers.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= IDLE;
      presc_q <= '0;
      sel_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sel   = sel_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule

// File: tb/tb_rotate_sel_ctrl.sv
// Directed bench for rotate_sel_ctrl with TICK_DIV=4, POSITIONS=4.
module tb_rotate_sel_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  logic       clk;
  logic       aclr;
  logic       run_en;
  logic       dir;
  logic       step_n;
  logic [1:0] sel;
  logic       tick;
  logic       wrap;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  rotate_sel_ctrl #(
    .TICK_DIV (4),
    .POSITIONS(4)
  ) dut (
    .clk   (clk),
    .aclr  (aclr),
    .run_en(run_en),
    .dir   (dir),
    .step_n(step_n),
    .sel   (sel),
    .tick  (tick),
    .wrap  (wrap),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    aclr = 1'b1; run_en = 1'b0; dir = 1'b0; step_n = 1'b1;
    #2;
    total++;
    if ({state, sel, tick, wrap} !== {ST_IDLE, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold: state=%0d sel=%0d tick=%0d wrap=%0d want 0 0 0 0", state, sel, tick, wrap);
    end
    @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);
    total++;
    if ({state, sel, tick} !== {ST_IDLE, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_idle: state=%0d sel=%0d tick=%0d want 0 0 0", state, sel, tick);
    end
    $display("reset: state=%0d sel=%0d", state, sel);
  endtask

  task automatic test_forward();
    logic [1:0] e_sel;
    logic       e_tick, e_wrap;
    run_en = 1'b1; dir = 1'b0;
    @(negedge clk);
    total++;
    if ({state, sel, tick} !== {ST_RUN, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL fwd_entry: state=%0d sel=%0d tick=%0d want 1 0 0", state, sel, tick);
    end
    e_sel = 2'd0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      e_tick = 1'b0; e_wrap = 1'b0;
      if (n == 4)  begin e_sel = 2'd1; e_tick = 1'b1; end
      if (n == 8)  begin e_sel = 2'd2; e_tick = 1'b1; end
      if (n == 12) begin e_sel = 2'd3; e_tick = 1'b1; end
      if (n == 16) begin e_sel = 2'd0; e_tick = 1'b1; e_wrap = 1'b1; end
      total++;
      if ({sel, tick, wrap} !== {e_sel, e_tick, e_wrap}) begin
        bad++;
        $display("FAIL fwd_cycle%0d: sel=%0d tick=%0d wrap=%0d want %0d %0d %0d", n, sel, tick, wrap, e_sel, e_tick, e_wrap);
      end
      if (e_tick) $display("fwd advance at %0d: sel=%0d wrap=%0d", n, sel, wrap);
    end
  endtask

  task automatic test_reverse();
    logic [1:0] e_sel;
    logic       e_tick, e_wrap;
    dir = 1'b1;
    e_sel = 2'd0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      e_tick = 1'b0; e_wrap = 1'b0;
      if (n == 4) begin e_sel = 2'd3; e_tick = 1'b1; e_wrap = 1'b1; end
      if (n == 8) begin e_sel = 2'd2; e_tick = 1'b1; end
      total++;
      if ({sel, tick, wrap} !== {e_sel, e_tick, e_wrap}) begin
        bad++;
        $display("FAIL rev_cycle%0d: sel=%0d tick=%0d wrap=%0d want %0d %0d %0d", n, sel, tick, wrap, e_sel, e_tick, e_wrap);
      end
      if (e_tick) $display("rev advance at %0d: sel=%0d wrap=%0d", n, sel, wrap);
    end
  endtask

  task automatic test_pause();
    // two cycles into the count, then pause
    repeat (2) @(negedge clk);
    run_en = 1'b0;
    @(negedge clk);
    total++;
    if ({state, sel, tick} !== {ST_PAUSE, 2'd2, 1'b0}) begin
      bad++;
      $display("FAIL pause_entry: state=%0d sel=%0d tick=%0d want 2 2 0", state, sel, tick);
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total++;
      if ({state, sel, tick} !== {ST_PAUSE, 2'd2, 1'b0}) begin
        bad++;
        $display("FAIL pause_hold%0d: state=%0d sel=%0d tick=%0d want 2 2 0", n, state, sel, tick);
      end
    end
    run_en = 1'b1;
    @(negedge clk);
    total++;
    if ({state, sel, tick} !== {ST_RUN, 2'd2, 1'b0}) begin
      bad++;
      $display("FAIL resume_entry: state=%0d sel=%0d tick=%0d want 1 2 0", state, sel, tick);
    end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      total++;
      if (n < 4) begin
        if ({sel, tick} !== {2'd2, 1'b0}) begin
          bad++;
          $display("FAIL resume_wait%0d: sel=%0d tick=%0d want 2 0", n, sel, tick);
        end
      end else begin
        if ({sel, tick, wrap} !== {2'd1, 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL resume_adv: sel=%0d tick=%0d wrap=%0d want 1 1 0", sel, tick, wrap);
        end
        $display("resume advance: sel=%0d", sel);
      end
    end
    run_en = 1'b0;
    @(negedge clk);
    total++;
    if ({state, sel} !== {ST_PAUSE, 2'd1}) begin
      bad++;
      $display("FAIL repause: state=%0d sel=%0d want 2 1", state, sel);
    end
  endtask

  task automatic test_step();
    logic [1:0] e_sel;
    logic       e_tick;
    dir = 1'b0;
    step_n = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      e_sel  = (c < 2) ? 2'd1 : 2'd2;
      e_tick = (c == 2);
      total++;
      if ({state, sel, tick, wrap} !== {ST_PAUSE, e_sel, e_tick, 1'b0}) begin
        bad++;
        $display("FAIL step_c%0d: state=%0d sel=%0d tick=%0d wrap=%0d want 2 %0d %0d 0", c, state, sel, tick, wrap, e_sel, e_tick);
      end
      if (e_tick) $display("step advance: sel=%0d", sel);
      if (c == 9) step_n = 1'b1;
    end
  endtask

  task automatic test_step_in_run();
    logic [1:0] e_sel;
    logic       e_tick, e_wrap;
    run_en = 1'b1;
    @(negedge clk);
    total++;
    if ({state, sel} !== {ST_RUN, 2'd2}) begin
      bad++;
      $display("FAIL run_step_entry: state=%0d sel=%0d want 1 2", state, sel);
    end
    step_n = 1'b0;
    e_sel = 2'd2;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      e_tick = 1'b0; e_wrap = 1'b0;
      if (n == 4) begin e_sel = 2'd3; e_tick = 1'b1; end
      if (n == 8) begin e_sel = 2'd0; e_tick = 1'b1; e_wrap = 1'b1; end
      total++;
      if ({state, sel, tick, wrap} !== {ST_RUN, e_sel, e_tick, e_wrap}) begin
        bad++;
        $display("FAIL run_step_c%0d: state=%0d sel=%0d tick=%0d wrap=%0d want 1 %0d %0d %0d", n, state, sel, tick, wrap, e_sel, e_tick, e_wrap);
      end
      if (n == 3) step_n = 1'b1;
    end
    $display("step in run: sel=%0d", sel);
  endtask

  task automatic test_coincident();
    run_en = 1'b0;
    @(negedge clk);
    total++;
    if ({state, sel} !== {ST_PAUSE, 2'd0}) begin
      bad++;
      $display("FAIL coin_pause: state=%0d sel=%0d want 2 0", state, sel);
    end
    step_n = 1'b0;
    @(negedge clk);               // after edge k
    @(negedge clk);               // after edge k+1: press event is now pending
    run_en = 1'b1;
    @(negedge clk);               // after edge k+2
    total++;
    if ({state, sel, tick} !== {ST_RUN, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL coin_drop: state=%0d sel=%0d tick=%0d want 1 0 0", state, sel, tick);
    end
    step_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      total++;
      if (n < 4) begin
        if ({sel, tick} !== {2'd0, 1'b0}) begin
          bad++;
          $display("FAIL coin_wait%0d: sel=%0d tick=%0d want 0 0", n, sel, tick);
        end
      end else begin
        if ({sel, tick, wrap} !== {2'd1, 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL coin_adv: sel=%0d tick=%0d wrap=%0d want 1 1 0", sel, tick, wrap);
        end
      end
    end
    $display("coincident: sel=%0d state=%0d", sel, state);
  endtask

  task automatic test_async_reset();
    repeat (8) @(negedge clk);
    total++;
    if ({state, sel, tick} !== {ST_RUN, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL prereset: state=%0d sel=%0d tick=%0d want 1 3 1", state, sel, tick);
    end
    #1 aclr = 1'b1;
    run_en = 1'b0;
    #1;
    total++;
    if ({state, sel, tick, wrap} !== {ST_IDLE, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: state=%0d sel=%0d tick=%0d wrap=%0d want 0 0 0 0", state, sel, tick, wrap);
    end
    #1 aclr = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({state, sel, tick} !== {ST_IDLE, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL post_reset: state=%0d sel=%0d tick=%0d want 0 0 0", state, sel, tick);
    end
    $display("async reset: state=%0d sel=%0d", state, sel);
  endtask

  task automatic test_idle_step();
    logic [1:0] e_state, e_sel;
    logic       e_tick;
    dir = 1'b1;
    step_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e_state = (c < 2) ? ST_IDLE : ST_PAUSE;
      e_sel   = (c < 2) ? 2'd0 : 2'd3;
      e_tick  = (c == 2);
      total++;
      if ({state, sel, tick, wrap} !== {e_state, e_sel, e_tick, e_tick}) begin
        bad++;
        $display("FAIL idle_step_c%0d: state=%0d sel=%0d tick=%0d wrap=%0d want %0d %0d %0d %0d", c, state, sel, tick, wrap, e_state, e_sel, e_tick, e_tick);
      end
      if (c == 3) step_n = 1'b1;
    end
    $display("idle step: state=%0d sel=%0d", state, sel);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_pause();
    test_step();
    test_step_in_run();
    test_coincident();
    test_async_reset();
    test_idle_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
